mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, address width of the storage array (2**ADDR_BITS rows).
REQ-002 Parameter DATA_BITS, default 8, data width of each row.
REQ-003 Parameter NUM_CHANNELS, default 4, number of independent request channels.
REQ-004 Parameter LATENCY, default 2, cycles from request capture to ready pulse; legal range 1..15.
REQ-005 Parameter WRITE_ENABLE, default 1; when 0 the write ports SHALL be ignored and write_ready held 0.
REQ-006 One clock; reset is synchronous and active-high; ports clk and reset.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 mem_read_valid  in  [NUM_CHANNELS]  per-channel read request, held until ready seen.
REQ-010 mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address, stable while valid.
REQ-011 mem_read_ready  out  [NUM_CHANNELS]  one-cycle read-complete pulse.
REQ-012 mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, valid while ready high.
REQ-013 mem_write_valid  in  [NUM_CHANNELS]  per-channel write request, held until ready seen.
REQ-014 mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address.
REQ-015 mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data.
REQ-016 mem_write_ready  out  [NUM_CHANNELS]  one-cycle write-complete pulse.
REQ-017 load_enable  in  1  bench/host preload strobe.
REQ-018 load_address  in  [ADDR_BITS]  preload address.
REQ-019 load_data  in  [DATA_BITS]  preload data.

Function
REQ-020 Each channel SHALL run its own FSM: IDLE, BUSY, RESPOND, DRAIN.
REQ-021 IDLE: at edge E0 with read_valid=1, capture address, op=read, load counter LATENCY-1, go BUSY (RESPOND directly if LATENCY=1).
REQ-022 IDLE with only write_valid=1 (WRITE_ENABLE=1): capture address/data, op=write, same counter rule.
REQ-023 IDLE with both valids high: read served first; write remains pending and is captured on a later IDLE.
REQ-024 BUSY: decrement counter each cycle; enter RESPOND at edge E0+LATENCY.
REQ-025 RESPOND: the op's ready SHALL be high for exactly one cycle, beginning at edge E0+LATENCY; next state DRAIN.
REQ-026 Read data SHALL be sampled from the array at edge E0+LATENCY (value before any write committing at that same edge) and held in mem_read_data until the next read response.
REQ-027 A write SHALL commit to the array at edge E0+LATENCY.
REQ-028 DRAIN: stay until the completed op's valid is sampled low, then IDLE; a valid still high SHALL NOT start a second transaction.
REQ-029 Request inputs changing while BUSY SHALL be ignored (captured values used).
REQ-030 Simultaneous writes to one address at one edge: lowest channel index wins; load_enable write beats all channels.
REQ-031 load_enable SHALL write load_data to load_address at the same edge, independent of channel FSMs.
REQ-032 Ready outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-033 Reset SHALL force all FSMs to IDLE, counters to 0, mem_read_ready, mem_write_ready and mem_read_data to 0.
REQ-034 Reset SHALL NOT clear the storage array; contents survive reset; load_enable during reset SHALL still write.
REQ-035 Reset mid-transaction SHALL abandon it: no ready pulse, a pending write SHALL NOT commit.

Structure
REQ-036 Shared package mem_pkg holds the channel state enum (IDLE, BUSY, RESPOND, DRAIN) and op-type constant.
REQ-037 One sub-module mem_channel_fsm per channel (generate loop); array and write arbitration live in mem_responder.

Verification
REQ-038 Preload addr 0x10=0x5A; ch0 read 0x10, LATENCY=2 -> read_ready[0] high one cycle at E0+2, read_data[0]=0x5A.
REQ-039 ch1 write 0x20<-0x33, then read 0x20 after DRAIN -> write_ready[1] one pulse; read returns 0x33.
REQ-040 ch0 and ch3 write 0x40 same edge (0x11, 0x22) -> array 0x40=0x11.
REQ-041 ch2 holds read_valid high 5 cycles after ready -> exactly one ready pulse; new request accepted only after valid low.
REQ-042 Assert reset one cycle into BUSY on a write 0x50<-0x77 (prior 0x01) -> no ready pulse, 0x50 reads 0x01, preloaded rows intact.
REQ-043 All 4 channels read distinct preloaded addresses same edge -> all four ready pulses same cycle with correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the multi-channel memory responder.
// Channel FSM states, op encoding and counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESPOND,
    ST_DRAIN
  } ch_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Wide enough for LATENCY up to 15.
  localparam int CNT_BITS = 4;

endpackage

// File: rtl/mem_channel_fsm.sv
// Per-channel request FSM: capture, count down, pulse ready, drain.
// Exposes a fire strobe on the commit edge for the shared array.
module mem_channel_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 fire,
  output logic                 op,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] wdata,
  output logic                 read_ready,
  output logic                 write_ready
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    CNT_BITS'(LATENCY - 1);

  ch_state_e             state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  op_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [DATA_BITS-1:0]  wdata_d;
  logic                  rd_rdy_d, wr_rdy_d;
  logic                  wr_req;
  logic                  op_valid;

  assign wr_req   = (WRITE_ENABLE != 0) && write_valid;
  assign op_valid = (op == OP_READ) ? read_valid
                                    : write_valid;

  // Commit edge: last BUSY cycle; a reset at that edge abandons it.
  assign fire = (state_q == ST_BUSY) &&
                (cnt_q == '0) && !reset;

  // State, captured request and registered ready pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op          <= OP_READ;
      addr        <= '0;
      wdata       <= '0;
      read_ready  <= 1'b0;
      write_ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op          <= op_d;
      addr        <= addr_d;
      wdata       <= wdata_d;
      read_ready  <= rd_rdy_d;
      write_ready <= wr_rdy_d;
    end
  end

  // Next-state and capture logic; reads win over writes in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op;
    addr_d   = addr;
    wdata_d  = wdata;
    rd_rdy_d = 1'b0;
    wr_rdy_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (read_valid) begin
          op_d    = OP_READ;
          addr_d  = read_address;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end else if (wr_req) begin
          op_d    = OP_WRITE;
          addr_d  = write_address;
          wdata_d = write_data;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_RESPOND;
          rd_rdy_d = (op == OP_READ);
          wr_rdy_d = (op == OP_WRITE);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESPOND: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!op_valid) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel fixed-latency memory responder with preload port.
// Owns the storage array, write arbitration and read data registers.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_enable,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [NUM_CHANNELS-1:0]                fire;
  logic [NUM_CHANNELS-1:0]                op;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    mem_channel_fsm #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .LATENCY      (LATENCY),
      .WRITE_ENABLE (WRITE_ENABLE)
    ) u_fsm (
      .clk           (clk),
      .reset         (reset),
      .read_valid    (mem_read_valid[g]),
      .read_address  (mem_read_address[g]),
      .write_valid   (mem_write_valid[g]),
      .write_address (mem_write_address[g]),
      .write_data    (mem_write_data[g]),
      .fire          (fire[g]),
      .op            (op[g]),
      .addr          (addr[g]),
      .wdata         (wdata[g]),
      .read_ready    (mem_read_ready[g]),
      .write_ready   (mem_write_ready[g])
    );
  end

  // Array writes: later assignments win, so high channels go first
  // and the preload port goes last.
  always_ff @(posedge clk) begin
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (fire[i] && op[i] == OP_WRITE)
        mem[addr[i]] <= wdata[i];
    end
    if (load_enable)
      mem[load_address] <= load_data;
  end

  // Read data sampled at the commit edge, held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (fire[i] && op[i] == OP_READ)
          mem_read_data[i] <= mem[addr[i]];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (default parameters).
// Table-driven transactions plus hand-written corner sequences.
module tb_mem_responder;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      rv;
  logic [3:0][7:0] ra;
  logic [3:0]      rr;
  logic [3:0][7:0] rd;
  logic [3:0]      wv;
  logic [3:0][7:0] wa;
  logic [3:0][7:0] wd;
  logic [3:0]      wr;
  logic            le;
  logic [7:0]      la;
  logic [7:0]      ldat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];
  int wr_pend [4];
  int rd_cnt  [4];
  int wr_cnt  [4];

  typedef struct {
    int         op;
    int         ch;
    logic [7:0] a;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [14];

  mem_responder dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_valid    (rv),
    .mem_read_address  (ra),
    .mem_read_ready    (rr),
    .mem_read_data     (rd),
    .mem_write_valid   (wv),
    .mem_write_address (wa),
    .mem_write_data    (wd),
    .mem_write_ready   (wr),
    .load_enable       (le),
    .load_address      (la),
    .load_data         (ldat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every ready pulse must match a pending expectation.
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (rr[ch]) begin
        int idx;
        idx = -1;
        rd_cnt[ch]++;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].ch == ch) idx = k;
        total++;
        if (idx < 0) begin
          bad++;
          $display("FAIL rd_unexpected ch=%0d got pulse data=%h want none",
                   ch, rd[ch]);
        end else begin
          if (rd[ch] !== sb[idx].data) begin
            bad++;
            $display("FAIL rd_data ch=%0d got=%h want=%h",
                     ch, rd[ch], sb[idx].data);
          end
          sb.delete(idx);
        end
      end
      if (wr[ch]) begin
        wr_cnt[ch]++;
        total++;
        if (wr_pend[ch] <= 0) begin
          bad++;
          $display("FAIL wr_unexpected ch=%0d got pulse want none", ch);
        end else begin
          wr_pend[ch]--;
        end
      end
    end
  end

  task automatic wait_bit(input int ch, input bit is_wr,
                          output int lat);
    bit seen;
    seen = 0;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (is_wr ? wr[ch] : rr[ch]) begin
          seen = 1;
          lat  = i;
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout ch=%0d wr=%0d got no ready want ready",
               ch, is_wr);
    end
  endtask

  task automatic check_lat(input string nm, input int got,
                           input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    le = 1'b1; la = a; ldat = d;
    @(negedge clk);
    le = 1'b0;
  endtask

  task automatic do_read(input int ch, input logic [7:0] a,
                         input logic [7:0] e);
    int lat;
    sb.push_back('{ch: ch, data: e});
    rv[ch] = 1'b1; ra[ch] = a;
    wait_bit(ch, 1'b0, lat);
    check_lat("read", lat, 3);
    rv[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input logic [7:0] a,
                          input logic [7:0] d);
    int lat;
    wr_pend[ch]++;
    wv[ch] = 1'b1; wa[ch] = a; wd[ch] = d;
    wait_bit(ch, 1'b1, lat);
    check_lat("write", lat, 3);
    wv[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int c0;
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
    le = 1'b0; la = '0; ldat = '0;
    for (int i = 0; i < 4; i++) begin
      wr_pend[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // Preloads during reset must still land.
    for (int i = 0; i < 4; i++)
      do_load(8'h70 + 8'(i), 8'h91 + 8'(i));
    total++;
    if (rr !== 4'h0 || wr !== 4'h0) begin
      bad++;
      $display("FAIL reset_ready got rr=%h wr=%h want 0 0", rr, wr);
    end
    total++;
    if (rd !== '0) begin
      bad++;
      $display("FAIL reset_rdata got=%h want=0", rd);
    end
    reset = 1'b0;
    @(negedge clk);

    tbl[0]  = '{0, 0, 8'h10, 8'h5A};
    tbl[1]  = '{2, 0, 8'h10, 8'h5A};
    tbl[2]  = '{1, 1, 8'h20, 8'h33};
    tbl[3]  = '{2, 1, 8'h20, 8'h33};
    tbl[4]  = '{0, 0, 8'h50, 8'h01};
    tbl[5]  = '{0, 0, 8'h60, 8'hA1};
    tbl[6]  = '{0, 0, 8'hFF, 8'hEE};
    tbl[7]  = '{0, 0, 8'h00, 8'h0F};
    tbl[8]  = '{2, 2, 8'h60, 8'hA1};
    tbl[9]  = '{1, 3, 8'h60, 8'hC4};
    tbl[10] = '{2, 0, 8'h60, 8'hC4};
    tbl[11] = '{2, 1, 8'hFF, 8'hEE};
    tbl[12] = '{2, 2, 8'h00, 8'h0F};
    tbl[13] = '{2, 3, 8'h50, 8'h01};

    foreach (tbl[i]) begin
      unique case (tbl[i].op)
        0: do_load(tbl[i].a, tbl[i].d);
        1: do_write(tbl[i].ch, tbl[i].a, tbl[i].d);
        default: do_read(tbl[i].ch, tbl[i].a, tbl[i].d);
      endcase
    end

    // Same-edge writes to one row: channel 0 must win.
    wr_pend[0]++; wr_pend[3]++;
    wv[0] = 1'b1; wa[0] = 8'h40; wd[0] = 8'h11;
    wv[3] = 1'b1; wa[3] = 8'h40; wd[3] = 8'h22;
    wait_bit(0, 1'b1, lat);
    total++;
    if (wr[3] !== 1'b1) begin
      bad++;
      $display("FAIL wr_same_edge ch3 got=%b want=1", wr[3]);
    end
    wv = '0;
    repeat (2) @(negedge clk);
    do_read(1, 8'h40, 8'h11);

    // Valid held after ready: one pulse only, data held.
    c0 = rd_cnt[2];
    sb.push_back('{ch: 2, data: 8'h5A});
    rv[2] = 1'b1; ra[2] = 8'h10;
    wait_bit(2, 1'b0, lat);
    ra[2] = 8'h20;
    repeat (5) @(negedge clk);
    total++;
    if (rd_cnt[2] != c0 + 1) begin
      bad++;
      $display("FAIL hold_pulses got=%0d want=%0d",
               rd_cnt[2] - c0, 1);
    end
    total++;
    if (rd[2] !== 8'h5A) begin
      bad++;
      $display("FAIL hold_data got=%h want=5a", rd[2]);
    end
    rv[2] = 1'b0;
    repeat (2) @(negedge clk);
    do_read(2, 8'h20, 8'h33);

    // Address change while busy is ignored.
    sb.push_back('{ch: 3, data: 8'h91});
    rv[3] = 1'b1; ra[3] = 8'h70;
    @(negedge clk);
    ra[3] = 8'h71;
    wait_bit(3, 1'b0, lat);
    check_lat("busy_change", lat, 2);
    rv[3] = 1'b0;
    repeat (2) @(negedge clk);

    // Read and write both pending: read first, then write.
    sb.push_back('{ch: 0, data: 8'h5A});
    wr_pend[0]++;
    rv[0] = 1'b1; ra[0] = 8'h10;
    wv[0] = 1'b1; wa[0] = 8'h30; wd[0] = 8'h44;
    wait_bit(0, 1'b0, lat);
    check_lat("rw_read", lat, 3);
    total++;
    if (wr[0] !== 1'b0) begin
      bad++;
      $display("FAIL rw_order got wr=%b want=0", wr[0]);
    end
    rv[0] = 1'b0;
    wait_bit(0, 1'b1, lat);
    check_lat("rw_write", lat, 5);
    wv[0] = 1'b0;
    repeat (2) @(negedge clk);
    do_read(1, 8'h30, 8'h44);

    // Reset one cycle into a write: abandoned, no commit.
    c0 = wr_cnt[1];
    wv[1] = 1'b1; wa[1] = 8'h50; wd[1] = 8'h77;
    @(negedge clk);
    reset = 1'b1; wv[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (rd !== '0) begin
      bad++;
      $display("FAIL midreset_rdata got=%h want=0", rd);
    end
    repeat (4) @(negedge clk);
    total++;
    if (wr_cnt[1] != c0) begin
      bad++;
      $display("FAIL midreset_pulse got=%0d want=0", wr_cnt[1] - c0);
    end
    do_read(1, 8'h50, 8'h01);
    do_read(0, 8'h10, 8'h5A);

    // All channels read distinct rows at one edge.
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ch: i, data: 8'h91 + 8'(i)});
      ra[i] = 8'h70 + 8'(i);
    end
    rv = 4'hF;
    wait_bit(0, 1'b0, lat);
    total++;
    if (rr !== 4'hF) begin
      bad++;
      $display("FAIL all_ch_ready got=%b want=1111", rr);
    end
    rv = '0;
    repeat (3) @(negedge clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    total++;
    if (wr_pend[0] + wr_pend[1] + wr_pend[2] + wr_pend[3] != 0) begin
      bad++;
      $display("FAIL wr_leftover got=%0d want=0",
               wr_pend[0] + wr_pend[1] + wr_pend[2] + wr_pend[3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
